// File: rtl/cpu_mem_ctrl_if.sv
// cpu_mem_ctrl_if: 16-bit req/ack halfword memory bus between cpu_mem_ctrl
// (master) and the external memory (slave).
interface cpu_mem_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [30:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/cpu_mem_ctrl.sv
// cpu_mem_ctrl: splits 8/16/32/48-bit core accesses into halfword beats on a
// req/ack memory bus, assembles read data little-endian and stalls the core
// until the access completes.
// Optional per-beat ack timeout: define CPU_MEM_CTRL_TIMEOUT_EN.
module cpu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_rd,
  input  logic                  cpu_req_wr,
  input  logic [1:0]            cpu_req_sz,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic                  cpu_enable,
  output logic [47:0]           cpu_data_in,
  output logic                  err,
  cpu_mem_ctrl_if.master        mem
);

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

  state_t      state, state_next;

  logic        req_any;
  logic        req_bad;
  logic        beat_ack;
  logic        start;
  logic        start_err;
  logic        beat_fire;

  logic        byte_q;       // access is a single byte
  logic        addr_lsb_q;   // byte lane select for byte accesses
  logic [15:0] wdata_hi_q;   // second-beat write data
  logic [1:0]  last_idx_q;   // index of the final beat
  logic [1:0]  beat_idx;     // current beat number

`ifdef CPU_MEM_CTRL_TIMEOUT_EN
  localparam int unsigned TW =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
`else
  // Timeout limit has no effect in this build; block only anchors the parameter.
  if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
  end
`endif

  assign req_any  = cpu_req_rd | cpu_req_wr;
  assign req_bad  = (cpu_req_rd & cpu_req_wr) |
                    ((cpu_req_sz != 2'd0) & cpu_addr[0]) |
                    (cpu_req_wr & (cpu_req_sz == 2'd3));
  assign beat_ack = mem.mem_req & mem.mem_ack;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode, core enable and datapath strobes
  always_comb begin
    state_next = state;
    start      = 1'b0;
    start_err  = 1'b0;
    beat_fire  = 1'b0;
`ifdef CPU_MEM_CTRL_TIMEOUT_EN
    tmo_hit    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req_any) begin
          if (req_bad) begin
            start_err  = 1'b1;
            state_next = DONE;
          end else begin
            start      = 1'b1;
            state_next = BEAT;
          end
        end
      end
      BEAT: begin
        if (beat_ack) begin
          beat_fire = 1'b1;
          if (beat_idx == last_idx_q) state_next = DONE;
        end
`ifdef CPU_MEM_CTRL_TIMEOUT_EN
        else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo_hit    = 1'b1;
          state_next = DONE;
        end
`endif
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    cpu_enable = ((state == IDLE) && !req_any) || (state == DONE);
  end

  // Request latch, beat sequencing and read-data assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= '0;
      mem.mem_wdata <= '0;
      cpu_data_in   <= '0;
      err           <= 1'b0;
      byte_q        <= 1'b0;
      addr_lsb_q    <= 1'b0;
      wdata_hi_q    <= '0;
      last_idx_q    <= '0;
      beat_idx      <= '0;
    end else begin
`ifdef CPU_MEM_CTRL_TIMEOUT_EN
      err <= start_err | tmo_hit;
`else
      err <= start_err;
`endif
      if (start) begin
        byte_q        <= (cpu_req_sz == 2'd0);
        addr_lsb_q    <= cpu_addr[0];
        wdata_hi_q    <= cpu_wdata[31:16];
        last_idx_q    <= (cpu_req_sz == 2'd3) ? 2'd2 :
                         (cpu_req_sz == 2'd2) ? 2'd1 : 2'd0;
        beat_idx      <= '0;
        mem.mem_req   <= 1'b1;
        mem.mem_we    <= cpu_req_wr;
        mem.mem_addr  <= cpu_addr[31:1];
        mem.mem_be    <= (cpu_req_sz != 2'd0) ? 2'b11 :
                         (cpu_addr[0] ? 2'b10 : 2'b01);
        mem.mem_wdata <= (cpu_req_sz == 2'd0) ? {cpu_wdata[7:0], cpu_wdata[7:0]}
                                              : cpu_wdata[15:0];
        if (cpu_req_rd) cpu_data_in <= '0;
      end
      if (beat_fire) begin
        if (!mem.mem_we) begin
          if (byte_q) begin
            cpu_data_in[7:0] <= addr_lsb_q ? mem.mem_rdata[15:8] : mem.mem_rdata[7:0];
          end else begin
            case (beat_idx)
              2'd0:    cpu_data_in[15:0]  <= mem.mem_rdata;
              2'd1:    cpu_data_in[31:16] <= mem.mem_rdata;
              default: cpu_data_in[47:32] <= mem.mem_rdata;
            endcase
          end
        end
        if (beat_idx == last_idx_q) begin
          mem.mem_req <= 1'b0;
        end else begin
          // Only 32-bit writes have a second write beat, so the upper
          // halfword is the only follow-on write data ever needed.
          beat_idx      <= beat_idx + 2'd1;
          mem.mem_addr  <= mem.mem_addr + 31'd1;
          mem.mem_wdata <= wdata_hi_q;
        end
      end
`ifdef CPU_MEM_CTRL_TIMEOUT_EN
      if (tmo_hit) begin
        mem.mem_req <= 1'b0;
        if (!mem.mem_we) cpu_data_in <= '0;
      end
`endif
    end
  end

`ifdef CPU_MEM_CTRL_TIMEOUT_EN
  // Consecutive unacked cycles within the current beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          tmo_cnt <= '0;
    else if (state == BEAT && !beat_fire) tmo_cnt <= tmo_cnt + 1'b1;
    else                              tmo_cnt <= '0;
  end
`endif

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// tb_cpu_mem_ctrl: randomized scoreboard bench for cpu_mem_ctrl with a
// reference memory and an access-level model of the expected beats/results.
module tb_cpu_mem_ctrl;
  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr;
  logic [1:0]  sz;
  logic [31:0] addr, wdata;
  logic        enable;
  logic [47:0] data_in;
  logic        err;

  cpu_mem_ctrl_if bus();

  cpu_mem_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req_rd  (rd),
    .cpu_req_wr  (wr),
    .cpu_req_sz  (sz),
    .cpu_addr    (addr),
    .cpu_wdata   (wdata),
    .cpu_enable  (enable),
    .cpu_data_in (data_in),
    .err         (err),
    .mem         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [30:0] addr;
    logic [1:0]  be;
    logic        we;
    logic [15:0] wdata;
  } beat_t;

  typedef struct {
    logic [47:0] data;
    logic        err;
    int unsigned nbeats;
    int unsigned stall_fixed;   // 0: derive from beats and inserted waits
  } done_t;

  beat_t        exp_beats[$];
  done_t        exp_done[$];
  int unsigned  vectors = 0;
  int unsigned  miscompares = 0;
  logic [15:0]  mem_arr [bit [30:0]];
  logic [47:0]  model_din = '0;
  int           never_ack = 0;
  int           fixed_wait = -1;
  int           wleft = -1;
  int unsigned  waits_ins = 0;
  bit           mon_en = 1'b0;

  function automatic logic [15:0] hw(bit [30:0] a);
    if (!mem_arr.exists(a)) mem_arr[a] = 16'($urandom);
    return mem_arr[a];
  endfunction

  function automatic void chk(string name, logic [47:0] act, logic [47:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Memory responder: random per-beat waits, spurious acks while idle
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        bus.mem_ack = 1'b0;
        wleft = -1;
      end else if (bus.mem_req) begin
        bus.mem_rdata = hw(bus.mem_addr);
        if (wleft < 0) wleft = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
        if (never_ack != 0 || wleft > 0) begin
          bus.mem_ack = 1'b0;
          waits_ins++;
          if (never_ack == 0) wleft--;
        end else begin
          bus.mem_ack = 1'b1;
          wleft = -1;
        end
      end else begin
        bus.mem_ack   = ($urandom_range(0, 3) == 0);
        bus.mem_rdata = 16'($urandom);
        wleft = -1;
      end
    end
  end

  // Monitor: checks every accepted beat and every completion
  initial begin
    automatic int unsigned stall = 0;
    beat_t b;
    done_t d;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        stall = 0;
        continue;
      end
      if (bus.mem_req && bus.mem_ack) begin
        if (exp_beats.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_beat: got addr 0x%0h, expected no beat", bus.mem_addr);
        end else begin
          b = exp_beats.pop_front();
          chk("beat_addr", 48'(bus.mem_addr), 48'(b.addr));
          chk("beat_be", 48'(bus.mem_be), 48'(b.be));
          chk("beat_we", 48'(bus.mem_we), 48'(b.we));
          if (b.we) chk("beat_wdata", 48'(bus.mem_wdata), 48'(b.wdata));
          chk("beat_err", 48'(err), 48'(0));
        end
      end
      if (!enable) begin
        stall++;
      end else if (rd || wr) begin
        if (exp_done.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_done: got completion, expected none");
        end else begin
          d = exp_done.pop_front();
          chk("done_data", data_in, d.data);
          chk("done_err", 48'(err), 48'(d.err));
          chk("beats_left", 48'(exp_beats.size()), 48'(0));
          chk("stall", 48'(stall),
              48'((d.stall_fixed != 0) ? d.stall_fixed : 1 + d.nbeats + waits_ins));
        end
        stall = 0;
      end
    end
  end

  task automatic apply_reset();
    mon_en = 1'b0;
    rst = 1'b1; rd = 1'b0; wr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_beats.delete();
    exp_done.delete();
    model_din  = '0;
    never_ack  = 0;
    fixed_wait = -1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Issue one access (caller is at posedge+1), push expectations, wait for completion
  task automatic access(input bit r, input bit w, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] wd, input bit tmo);
    automatic bit          bad = (r && w) || (s != 2'd0 && a[0]) || (w && s == 2'd3);
    automatic int unsigned n = (s == 2'd3) ? 3 : (s == 2'd2) ? 2 : 1;
    automatic bit [30:0]   ba;
    automatic logic [15:0] h;
    automatic logic [47:0] dat;
    automatic bit          got = 1'b0;
    done_t d;
    beat_t b;
    d.err = bad; d.nbeats = 0; d.stall_fixed = 0;
    if (bad) begin
      d.data = model_din;
    end else if (tmo) begin
      d.err = 1'b1;
      d.stall_fixed = 1 + TMO;
      if (r) model_din = '0;
      d.data = model_din;
    end else begin
      d.nbeats = n;
      dat = '0;
      for (int k = 0; k < int'(n); k++) begin
        ba = a[31:1] + 31'(k);
        h = hw(ba);
        b.addr  = ba;
        b.be    = (s != 2'd0) ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
        b.we    = w;
        b.wdata = (s == 2'd0) ? {wd[7:0], wd[7:0]} : ((k == 0) ? wd[15:0] : wd[31:16]);
        exp_beats.push_back(b);
        if (w) begin
          if (b.be[0]) h[7:0]  = b.wdata[7:0];
          if (b.be[1]) h[15:8] = b.wdata[15:8];
          mem_arr[ba] = h;
        end else if (s == 2'd0) begin
          dat[7:0] = a[0] ? h[15:8] : h[7:0];
        end else begin
          dat[16*k +: 16] = h;
        end
      end
      if (r) model_din = dat;
      d.data = model_din;
    end
    exp_done.push_back(d);
    waits_ins = 0;
    rd = r; wr = w; sz = s; addr = a; wdata = wd;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (enable && (rd || wr)) got = 1'b1;
    end
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL completion_timeout: got no completion in 300 cycles, expected completion");
      apply_reset();
    end
  endtask

  initial begin
    automatic int unsigned bad_cycles = 0;
    automatic int          sel;
    automatic bit          r, w;
    automatic logic [1:0]  s;
    automatic logic [31:0] a;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; sz = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 48'(bus.mem_req), 48'(0));
    chk("rst_mem_we", 48'(bus.mem_we), 48'(0));
    chk("rst_mem_addr", 48'(bus.mem_addr), 48'(0));
    chk("rst_mem_be", 48'(bus.mem_be), 48'(0));
    chk("rst_mem_wdata", 48'(bus.mem_wdata), 48'(0));
    chk("rst_data_in", data_in, 48'(0));
    chk("rst_err", 48'(err), 48'(0));
    chk("rst_enable", 48'(enable), 48'(1));
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Directed: 48-bit zero-wait fetch, odd byte read with 2 waits, 32-bit write
    mem_arr[31'h80] = 16'h3322;
    mem_arr[31'h81] = 16'h5544;
    mem_arr[31'h82] = 16'h7766;
    fixed_wait = 0;
    access(1, 0, 2'd3, 32'h0000_0100, 32'h0, 0);
    mem_arr[31'h3] = 16'hAB12;
    fixed_wait = 2;
    access(1, 0, 2'd0, 32'h0000_0007, 32'h0, 0);
    fixed_wait = -1;
    access(0, 1, 2'd2, 32'h0000_0020, 32'hDEAD_BEEF, 0);
    // Errors and address wrap
    access(1, 0, 2'd1, 32'h0000_0003, 32'h0, 0);
    access(1, 1, 2'd2, 32'h0000_0040, 32'h0, 0);
    access(0, 1, 2'd3, 32'h0000_0040, 32'h1234_5678, 0);
    access(1, 0, 2'd2, 32'hFFFF_FFFE, 32'h0, 0);
    access(0, 1, 2'd0, 32'h0000_0031, 32'h0000_005A, 0);
    access(1, 0, 2'd1, 32'h0000_0030, 32'h0, 0);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 19));
      r = (sel < 10) || (sel == 19);
      w = (sel >= 10);
      s = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                      : 32'($urandom_range(0, 255));
      if (s != 2'd0 && $urandom_range(0, 4) != 0) a[0] = 1'b0;
      access(r, w, s, a, $urandom, 0);
    end

    // Reset in the middle of a 48-bit read
    mem_arr[31'h200] = 16'h1234;
    access(1, 0, 2'd1, 32'h0000_0400, 32'h0, 0);
    mon_en = 1'b0;
    never_ack = 1;
    rd = 1'b1; sz = 2'd3; addr = 32'h0000_0500;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_mem_req", 48'(bus.mem_req), 48'(0));
    chk("midrst_data_in", data_in, 48'(0));
    rd = 1'b0;
    #1;
    chk("midrst_enable", 48'(enable), 48'(1));
    apply_reset();

`ifdef CPU_MEM_CTRL_TIMEOUT_EN
    access(1, 0, 2'd1, 32'h0000_0400, 32'h0, 0);
    never_ack = 1;
    access(1, 0, 2'd2, 32'h0000_0600, 32'h0, 1);
    access(1, 0, 2'd1, 32'h0000_0400, 32'h0, 0);
    never_ack = 1;
    access(0, 1, 2'd1, 32'h0000_0600, 32'h0000_9999, 1);
    never_ack = 0;
`else
    mon_en = 1'b0;
    never_ack = 1;
    rd = 1'b1; sz = 2'd1; addr = 32'h0000_0600;
    @(negedge clk);
    repeat (120) begin
      @(negedge clk);
      if (err || !bus.mem_req) bad_cycles++;
    end
    chk("hold_no_err", 48'(bad_cycles), 48'(0));
    apply_reset();
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end

endmodule
